// File: rtl/apb_master_bridge_if.sv
// ---------------------------------------------------------------------------
// apb_master_bridge_if
// Bundles the request/response handshake and the APB3 bus of the
// single-outstanding APB initiator.
//
// Signal groups
//   request  : req_valid, req_ready, req_addr, req_write, req_wdata
//   response : rsp_valid, rsp_ready, rsp_rdata, rsp_err
//   APB      : PADDR, PWDATA, PWRITE, PSEL, PENABLE, PRDATA, PREADY, PSLVERR
//
// Modports
//   master : the bridge side (accepts requests, drives the APB bus)
//   slave  : the environment side (issues requests, models the APB slave)
// ---------------------------------------------------------------------------
interface apb_master_bridge_if #(
    parameter int APB_ADDR_WIDTH = 12
);
    logic                      req_valid;
    logic                      req_ready;
    logic [APB_ADDR_WIDTH-1:0] req_addr;
    logic                      req_write;
    logic [31:0]               req_wdata;

    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [31:0]               rsp_rdata;
    logic                      rsp_err;

    logic [APB_ADDR_WIDTH-1:0] PADDR;
    logic [31:0]               PWDATA;
    logic                      PWRITE;
    logic                      PSEL;
    logic                      PENABLE;
    logic [31:0]               PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;

    modport master (
        input  req_valid, req_addr, req_write, req_wdata,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        output req_valid, req_addr, req_write, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_master_bridge.sv
// ---------------------------------------------------------------------------
// apb_master_bridge
// Single-outstanding APB3 initiator. A valid/ready request is turned into one
// SETUP + ACCESS transfer; the result is returned on a valid/ready response
// channel. A wait-state timeout forces an error response when the slave never
// asserts PREADY.
//
// Ports
//   HCLK    : clock, all state on the rising edge
//   HRESETn : asynchronous active-low reset
//   bus     : apb_master_bridge_if.master (request, response and APB signals)
//
// Parameters
//   APB_ADDR_WIDTH : width of req_addr / PADDR
//   TIMEOUT_CYCLES : ACCESS cycles allowed before an error response, 0 = off
// ---------------------------------------------------------------------------
module apb_master_bridge #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    apb_master_bridge_if.master    bus
);

    // Keep the counter at least one bit wide even when the timeout is off.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    // The counter reads 0 in the first ACCESS cycle, so the TIMEOUT_CYCLES-th
    // ACCESS cycle is the one where it reads TIMEOUT_CYCLES-1.
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } state_t;

    state_t                    r_state;
    state_t                    w_state_next;

    logic [APB_ADDR_WIDTH-1:0] r_paddr;
    logic [31:0]               r_pwdata;
    logic                      r_pwrite;
    logic [31:0]               r_rsp_rdata;
    logic                      r_rsp_err;
    logic [CNT_W-1:0]          r_cnt;

    logic                      w_accept;
    logic                      w_done;
    logic                      w_expire;
    logic                      w_last_cycle;

    assign w_last_cycle = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST);

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state and per-cycle strobes
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_done       = 1'b0;
        w_expire     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                // A slave completing in the last allowed cycle beats the timeout.
                if (bus.PREADY) begin
                    w_done       = 1'b1;
                    w_state_next = ST_RESP;
                end else if (w_last_cycle) begin
                    w_expire     = 1'b1;
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath: request capture, response capture, wait counter
    // -----------------------------------------------------------------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_pwrite    <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_cnt       <= '0;
        end else begin
            // Address/data/direction change only on acceptance, so they stay
            // stable across SETUP/ACCESS and hold between transfers.
            if (w_accept) begin
                r_paddr  <= bus.req_addr;
                r_pwdata <= bus.req_wdata;
                r_pwrite <= bus.req_write;
            end

            // PRDATA/PSLVERR are only looked at when PREADY completes the
            // transfer; write responses never carry read data.
            if (w_done) begin
                r_rsp_err   <= bus.PSLVERR;
                r_rsp_rdata <= r_pwrite ? 32'h0 : bus.PRDATA;
            end else if (w_expire) begin
                r_rsp_err   <= 1'b1;
                r_rsp_rdata <= 32'h0;
            end

            // Cleared in SETUP so that it reads 0 in the first ACCESS cycle.
            if (r_state == ST_SETUP) begin
                r_cnt <= '0;
            end else if ((r_state == ST_ACCESS) && (r_cnt != CNT_MAX)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: decoded from the state register or taken straight from flops
    // -----------------------------------------------------------------------
    assign bus.req_ready = (r_state == ST_IDLE);
    assign bus.PSEL      = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
    assign bus.PENABLE   = (r_state == ST_ACCESS);
    assign bus.rsp_valid = (r_state == ST_RESP);
    assign bus.PADDR     = r_paddr;
    assign bus.PWDATA    = r_pwdata;
    assign bus.PWRITE    = r_pwrite;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_master_bridge.sv
// ---------------------------------------------------------------------------
// tb_apb_master_bridge
// Directed bench for apb_master_bridge. Each request pushes its hand-computed
// response into a queue; an independent monitor pops and compares on every
// response handshake. A small APB slave process answers ACCESS cycles with a
// configurable number of wait states.
// ---------------------------------------------------------------------------
module tb_apb_master_bridge;

    localparam int AW = 12;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic HCLK;
    logic HRESETn;

    apb_master_bridge_if #(.APB_ADDR_WIDTH(AW)) bus ();

    apb_master_bridge #(
        .APB_ADDR_WIDTH(AW),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .HCLK   (HCLK),
        .HRESETn(HRESETn),
        .bus    (bus)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int n_checks = 0;
    int n_fail   = 0;

    rsp_t exp_q[$];

    // Current transfer as seen by the stability monitor and the slave model
    logic [AW-1:0] exp_addr;
    logic          exp_wr;
    logic [31:0]   exp_wdata;
    int            slv_wait;
    logic          slv_err;
    logic          slv_pulse;
    logic [31:0]   slv_rdata;
    int            acc_k;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    // APB slave: PREADY on the (slv_wait+1)-th ACCESS cycle; optional
    // PSLVERR noise during wait states; garbage PRDATA until ready.
    always @(posedge HCLK) begin
        #1;
        if (HRESETn && bus.PENABLE) begin
            bus.PREADY  = (acc_k == slv_wait);
            bus.PSLVERR = (acc_k == slv_wait) ? slv_err : slv_pulse;
            bus.PRDATA  = (acc_k == slv_wait) ? slv_rdata : 32'hBADC0DE0;
            acc_k++;
        end else begin
            acc_k       = 0;
            bus.PREADY  = 1'b0;
            bus.PSLVERR = 1'b0;
            bus.PRDATA  = 32'h0;
        end
    end

    // Response monitor / scoreboard
    always @(negedge HCLK) begin
        if (HRESETn && bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rsp: got rdata=0x%08h err=%0b required none", bus.rsp_rdata, bus.rsp_err);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                $display("rsp: rdata=0x%08h err=%0b (expect 0x%08h/%0b)", bus.rsp_rdata, bus.rsp_err, e.rdata, e.err);
                chk("rsp_rdata", bus.rsp_rdata, e.rdata);
                chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
            end
        end
    end

    // APB address/data/direction must stay stable while selected
    always @(negedge HCLK) begin
        if (HRESETn && bus.PSEL) begin
            chk("paddr_stable", 32'(bus.PADDR), 32'(exp_addr));
            chk("pwrite_stable", 32'(bus.PWRITE), 32'(exp_wr));
            chk("pwdata_stable", bus.PWDATA, exp_wdata);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic arm(input logic [AW-1:0] addr, input logic wr, input logic [31:0] wdata,
                       input int wait_n, input logic err, input logic pulse, input logic [31:0] prdata,
                       input logic [31:0] e_rdata, input logic e_err, input bit push);
        rsp_t e;
        exp_addr  = addr;
        exp_wr    = wr;
        exp_wdata = wdata;
        slv_wait  = wait_n;
        slv_err   = err;
        slv_pulse = pulse;
        slv_rdata = prdata;
        if (push) begin
            e.rdata = e_rdata;
            e.err   = e_err;
            exp_q.push_back(e);
        end
    endtask

    // Called right after the acceptance edge; returns on the negedge where
    // rsp_valid is first seen.
    task automatic wait_rsp(input int exp_acc);
        int  psel_n = 0;
        int  pen_n  = 0;
        int  lat    = 0;
        bit  got    = 0;
        for (int c = 1; c <= 60 && !got; c++) begin
            @(negedge HCLK);
            if (c == 1) begin
                chk("setup_psel", 32'(bus.PSEL), 32'd1);
                chk("setup_penable", 32'(bus.PENABLE), 32'd0);
            end
            if (bus.PSEL) psel_n++;
            if (bus.PENABLE) pen_n++;
            if (bus.rsp_valid) begin
                got = 1;
                lat = c;
            end
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL rsp_wait: rsp_valid not seen within 60 cycles, required after %0d", exp_acc + 2);
        end else begin
            chk("rsp_latency", 32'(lat), 32'(exp_acc + 2));
            chk("penable_cycles", 32'(pen_n), 32'(exp_acc));
            chk("psel_cycles", 32'(psel_n), 32'(exp_acc + 1));
        end
    endtask

    task automatic run_xfer(input logic [AW-1:0] addr, input logic wr, input logic [31:0] wdata,
                            input int wait_n, input logic err, input logic pulse, input logic [31:0] prdata,
                            input logic [31:0] e_rdata, input logic e_err, input int exp_acc);
        @(posedge HCLK);
        #1;
        arm(addr, wr, wdata, wait_n, err, pulse, prdata, e_rdata, e_err, 1'b1);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.req_write = wr;
        bus.req_wdata = wdata;
        @(negedge HCLK);
        chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
        @(posedge HCLK);
        #1;
        bus.req_valid = 1'b0;
        wait_rsp(exp_acc);
    endtask

    initial begin
        HRESETn       = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_write = 1'b0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b1;
        arm('0, 1'b0, 32'h0, 0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Reset state
        repeat (2) @(negedge HCLK);
        chk("rst_psel", 32'(bus.PSEL), 32'd0);
        chk("rst_penable", 32'(bus.PENABLE), 32'd0);
        chk("rst_pwrite", 32'(bus.PWRITE), 32'd0);
        chk("rst_paddr", 32'(bus.PADDR), 32'd0);
        chk("rst_pwdata", bus.PWDATA, 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        #2 HRESETn = 1'b1;

        // Zero-wait read
        run_xfer(12'h008, 1'b0, 32'h0, 0, 1'b0, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1);
        // Write with 3 wait states, read data ignored
        run_xfer(12'h010, 1'b1, 32'h000000FF, 3, 1'b0, 1'b0, 32'hAAAA5555, 32'h0, 1'b0, 4);
        // Slave error on read, data still returned
        run_xfer(12'h00C, 1'b0, 32'h0, 0, 1'b1, 1'b0, 32'h12345678, 32'h12345678, 1'b1, 1);
        // PSLVERR noise during wait states is ignored
        run_xfer(12'h004, 1'b0, 32'h0, 2, 1'b0, 1'b1, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 3);
        // Timeout on read: 16 ACCESS cycles, error, zero data
        run_xfer(12'h018, 1'b0, 32'h0, 1000, 1'b0, 1'b0, 32'h11112222, 32'h0, 1'b1, 16);
        // PREADY on the 16th ACCESS cycle beats the timeout
        run_xfer(12'h01C, 1'b0, 32'h0, 15, 1'b0, 1'b0, 32'h33334444, 32'h33334444, 1'b0, 16);
        // Timeout on write
        run_xfer(12'h020, 1'b1, 32'h0000005A, 1000, 1'b0, 1'b0, 32'h55556666, 32'h0, 1'b1, 16);

        // Response back-pressure with a second request waiting
        @(posedge HCLK);
        #1;
        bus.rsp_ready = 1'b0;
        arm(12'h030, 1'b0, 32'h0, 0, 1'b0, 1'b0, 32'h0BADF00D, 32'h0BADF00D, 1'b0, 1'b1);
        bus.req_valid = 1'b1;
        bus.req_addr  = 12'h030;
        bus.req_write = 1'b0;
        bus.req_wdata = 32'h0;
        @(negedge HCLK);
        chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
        @(posedge HCLK);
        #1;
        bus.req_valid = 1'b0;
        wait_rsp(1);
        @(posedge HCLK);
        #1;
        arm(12'h034, 1'b1, 32'h00C0FFEE, 0, 1'b0, 1'b0, 32'h77777777, 32'h0, 1'b0, 1'b1);
        bus.req_valid = 1'b1;
        bus.req_addr  = 12'h034;
        bus.req_write = 1'b1;
        bus.req_wdata = 32'h00C0FFEE;
        repeat (5) begin
            @(negedge HCLK);
            chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_rsp_rdata", bus.rsp_rdata, 32'h0BADF00D);
            chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
        end
        @(posedge HCLK);
        #1;
        bus.rsp_ready = 1'b1;
        @(posedge HCLK);
        #1;
        @(negedge HCLK);
        chk("next_req_ready", 32'(bus.req_ready), 32'd1);
        @(posedge HCLK);
        #1;
        bus.req_valid = 1'b0;
        wait_rsp(1);

        // Asynchronous reset during ACCESS
        @(posedge HCLK);
        #1;
        arm(12'h040, 1'b1, 32'h00000077, 1000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        bus.req_valid = 1'b1;
        bus.req_addr  = 12'h040;
        bus.req_write = 1'b1;
        bus.req_wdata = 32'h00000077;
        @(posedge HCLK);
        #1;
        bus.req_valid = 1'b0;
        repeat (3) @(negedge HCLK);
        chk("pre_rst_penable", 32'(bus.PENABLE), 32'd1);
        #2 HRESETn = 1'b0;
        #1;
        chk("arst_psel", 32'(bus.PSEL), 32'd0);
        chk("arst_penable", 32'(bus.PENABLE), 32'd0);
        @(negedge HCLK);
        #2 HRESETn = 1'b1;
        @(negedge HCLK);
        chk("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("post_rst_paddr", 32'(bus.PADDR), 32'd0);
        chk("post_rst_psel", 32'(bus.PSEL), 32'd0);

        // Normal operation resumes after reset
        run_xfer(12'h044, 1'b0, 32'h0, 0, 1'b0, 1'b0, 32'h600DCAFE, 32'h600DCAFE, 1'b0, 1);
        @(posedge HCLK);
        #1;
        repeat (2) @(negedge HCLK);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
